pc_stack_unit: RTL and testbench

Parametrised program-counter unit with an integrated return-address stack, succeeding the fixed two-bit `pc_state` PC path and push/pop stack of the current CPU datapath. It sequences the fetch address each cycle through one of four operations: increment, conditional jump, call and return. It adds stall, configurable address width and stack depth, full/empty status, and sticky overflow/underflow error flags. It sits in the datapath between the controller (`pc_op`, `take`, `stall`) and instruction memory (`pc`).

---
 rtl/cpu_pkg.sv | 13 +
 rtl/lifo_stack.sv | 49 ++++
 rtl/pc_stack_unit.sv | 100 ++++++++++
 tb/tb_pc_stack_unit.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: program-counter operation encoding.
package cpu_pkg;

  localparam int PC_OP_W = 2;

  typedef enum logic [PC_OP_W-1:0] {
    PC_NEXT = 2'd0,
    PC_JUMP = 2'd1,
    PC_CALL = 2'd2,
    PC_RET  = 2'd3
  } pc_op_t;

endpackage

// File: rtl/lifo_stack.sv
// Register-array LIFO with an occupancy counter; pushes when full and pops when empty are dropped.
module lifo_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] count_m1;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty && !push;
  assign count_m1 = count - CNT_W'(1);
  // Read index is meaningless when empty; callers gate pop on empty.
  assign top      = mem[count_m1[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (do_push) begin
      count <= count + CNT_W'(1);
    end else if (do_pop) begin
      count <= count_m1;
    end
  end

  // Contents need no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[count[IDX_W-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Fetch-address sequencer: increment, conditional jump, call and return with a return-address stack.
module pc_stack_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = 12,
  parameter int                DEPTH     = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  localparam int               SP_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  pc_op_t            pc_op,
  input  logic              take,
  input  logic [ADDR_W-1:0] target,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] pc,
  output logic [SP_W-1:0]   sp,
  output logic              full,
  output logic              empty,
  output logic              ovf_err,
  output logic              unf_err
);

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] stack_top;
  logic              push;
  logic              pop;
  logic              ovf_set;
  logic              unf_set;

  assign pc_inc = pc + ADDR_W'(1);

  always_comb begin
    pc_nxt  = pc;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (!stall) begin
      unique case (pc_op)
        PC_NEXT: pc_nxt = pc_inc;
        PC_JUMP: pc_nxt = take ? target : pc_inc;
        PC_CALL: begin
          if (full) begin
            ovf_set = 1'b1;
          end else begin
            push   = 1'b1;
            pc_nxt = target;
          end
        end
        PC_RET: begin
          if (empty) begin
            unf_set = 1'b1;
          end else begin
            pop    = 1'b1;
            pc_nxt = stack_top;
          end
        end
        default: pc_nxt = pc;
      endcase
    end
  end

  lifo_stack #(
    .WIDTH(ADDR_W),
    .DEPTH(DEPTH)
  ) u_stack (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .wdata(pc_inc),
    .top  (stack_top),
    .full (full),
    .empty(empty),
    .count(sp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_VEC;
    end else begin
      pc <= pc_nxt;
    end
  end

  // A new fault in the same cycle as clr_err leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      ovf_err <= ovf_set | (ovf_err & ~clr_err);
      unf_err <= unf_set | (unf_err & ~clr_err);
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit: directed scenarios then random ops against a queue-based model.
module tb_pc_stack_unit;
  import cpu_pkg::*;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 8;

  typedef struct packed {
    logic [11:0] pc;
    logic [3:0]  sp;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        unf;
  } obs_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              stall = 1'b0;
  pc_op_t            pc_op = PC_NEXT;
  logic              take = 1'b0;
  logic [ADDR_W-1:0] target = '0;
  logic              clr_err = 1'b0;
  logic [ADDR_W-1:0] pc;
  logic [3:0]        sp;
  logic              full, empty, ovf_err, unf_err;

  pc_stack_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_VEC('0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_op(pc_op), .take(take),
    .target(target), .clr_err(clr_err), .pc(pc), .sp(sp), .full(full),
    .empty(empty), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  // Reference model: PC value, return addresses as a plain queue, flags.
  logic [11:0] m_pc = '0;
  logic [11:0] m_ret[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic step(input logic r, input logic s, input pc_op_t o,
                      input logic t, input logic [11:0] tg, input logic c);
    obs_t e;
    logic ov, un;
    @(negedge clk);
    rst = r; stall = s; pc_op = o; take = t; target = tg; clr_err = c;
    ov = 1'b0; un = 1'b0;
    if (r) begin
      m_pc = '0; m_ret.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (!s) begin
        case (o)
          PC_NEXT: m_pc = m_pc + 12'd1;
          PC_JUMP: m_pc = t ? tg : m_pc + 12'd1;
          PC_CALL: if (m_ret.size() >= DEPTH) ov = 1'b1;
                   else begin m_ret.push_back(m_pc + 12'd1); m_pc = tg; end
          PC_RET:  if (m_ret.size() == 0) un = 1'b1;
                   else m_pc = m_ret.pop_back();
          default: ;
        endcase
      end
      m_ovf = ov | (m_ovf & ~c);
      m_unf = un | (m_unf & ~c);
    end
    e.pc = m_pc; e.sp = 4'(m_ret.size());
    e.full = (m_ret.size() == DEPTH); e.empty = (m_ret.size() == 0);
    e.ovf = m_ovf; e.unf = m_unf;
    exp_q.push_back(e);
  endtask

  // Monitor: every edge produces one observable state; compare against the oldest expectation.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{pc: pc, sp: sp, full: full, empty: empty, ovf: ovf_err, unf: unf_err};
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL state chk#%0d: got pc=%h sp=%0d full=%b empty=%b ovf=%b unf=%b, want pc=%h sp=%0d full=%b empty=%b ovf=%b unf=%b",
                      n_checks, a.pc, a.sp, a.full, a.empty, a.ovf, a.unf,
                      e.pc, e.sp, e.full, e.empty, e.ovf, e.unf);
      end
    end
  end

  initial begin
    int wait_cyc;
    // Reset with a CALL presented at the same time.
    step(1, 0, PC_CALL, 0, 12'h100, 0);
    step(1, 0, PC_NEXT, 0, 12'h000, 0);
    // Increment and jump.
    repeat (3) step(0, 0, PC_NEXT, 0, 12'h000, 0);
    step(0, 0, PC_JUMP, 0, 12'h123, 0);
    step(0, 0, PC_JUMP, 1, 12'h7F0, 0);
    step(0, 0, PC_JUMP, 1, 12'hFFF, 0);
    step(0, 0, PC_NEXT, 0, 12'h000, 0);
    // Nested calls.
    step(0, 0, PC_JUMP, 1, 12'h010, 0);
    step(0, 0, PC_CALL, 0, 12'h200, 0);
    step(0, 0, PC_CALL, 0, 12'h300, 0);
    step(0, 0, PC_RET,  0, 12'h000, 0);
    step(0, 0, PC_RET,  0, 12'h000, 0);
    // Overflow then LIFO unwind.
    for (int i = 0; i < DEPTH; i++) step(0, 0, PC_CALL, 0, 12'(12'h400 + i * 16), 0);
    step(0, 0, PC_CALL, 0, 12'h555, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, PC_RET, 0, 12'h000, 0);
    // Underflow and clear.
    step(0, 0, PC_RET, 0, 12'h000, 0);
    step(0, 0, PC_RET, 0, 12'h000, 1);
    step(0, 0, PC_NEXT, 0, 12'h000, 1);
    // Stall holds a CALL, then it executes.
    for (int i = 0; i < 3; i++) step(0, 1, PC_CALL, 0, 12'hABC, 0);
    step(0, 0, PC_CALL, 0, 12'hABC, 0);
    step(0, 0, PC_RET, 0, 12'h000, 0);
    // Fault during stall is not raised; clr_err still acts while stalled.
    step(0, 0, PC_RET, 0, 12'h000, 0);
    step(0, 1, PC_RET, 0, 12'h000, 1);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 6) == 0),
           pc_op_t'(2'($urandom_range(0, 3))), 1'($urandom_range(0, 1)),
           12'($urandom), ($urandom_range(0, 11) == 0));
    end
    @(negedge clk);
    stall = 1'b1;
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
